fft_addr_sched: RTL and testbench
=================================

Name: fft_addr_sched

Overview:
- Sequences an in-place radix-2 decimation-in-time FFT of N = 2^LOG2N points held in a single-port complex sample RAM.
- Each cycle it may issue one butterfly: read/write address pair plus the 4-bit twiddle index, which drives the 16-entry twiddle ROM (W16^k, Q1.15).
- Runs stage by stage, inserting a programmable drain gap between stages so butterfly pipeline write-backs land before the next stage reads.
- Sits between the top-level FFT control (start/done) and the butterfly datapath.

Parameters:
- LOG2N, 4, log2 of transform size; legal 2..4 (ROM resolution limits N to 16).
- DRAIN, 3, idle cycles after a stage's last accepted butterfly; equals butterfly pipeline depth; legal 0..15.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a transform; honoured only in IDLE
- busy  output  1  high from the cycle after an accepted start until done
- bf_valid  output  1  the address/twiddle set is valid this cycle
- bf_ready  input  1  butterfly datapath accepts; issue on bf_valid && bf_ready
- addr_a  output  LOG2N  upper-leg sample address
- addr_b  output  LOG2N  lower-leg sample address
- tw_index  output  4  twiddle ROM index
- stage  output  2  current stage 0..LOG2N-1
- last_bf  output  1  marks the final butterfly of the final stage (qualified by bf_valid)
- done  output  1  one-cycle pulse when the transform completes

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; busy, bf_valid, last_bf, done = 0; addr_a, addr_b, tw_index, stage, and the internal counters j and drain_cnt = 0.
- States and transitions:
  - IDLE: start -> ISSUE next cycle with stage=0 and j=0.
  - ISSUE: bf_valid=1. On each handshake, j increments. On the handshake where j=N/2-1: if stage<LOG2N-1, go to DRAIN; otherwise go to DRAIN with a final flag set.
  - DRAIN: bf_valid=0 for exactly DRAIN cycles. Then either stage+1 and j=0 and back to ISSUE, or, if the final flag is set, go to DONE. When DRAIN=0, the next-stage issue starts the cycle after the last handshake.
  - DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- Address generation for butterfly j at stage s, combinational from registered j and s:
  - span = 2^s, grp = j>>s, k = j&(span-1)
  - addr_a = grp*2*span + k; addr_b = addr_a + span
  - tw_index = k<<(3-s), truncated to 4 bits; always in 0..7 for the forward transform
- Outputs hold stable while bf_valid && !bf_ready; stalls of any length are legal.
- start in any state other than IDLE is ignored; no queuing.
- start and a reset deassertion in the same cycle: reset wins, and start is ignored until rst_n has been seen high on a prior edge.
- Reset asserted mid-transform aborts immediately with no done pulse.
- Forward transform totals: (N/2)*LOG2N handshakes. With no stalls, start -> done latency = 1 + LOG2N*(N/2 + DRAIN) + 1 cycles.

Optional Feature:
- Macro: FFT_INVERSE_EN.
- Defined: adds input port inverse (1 bit), sampled at an accepted start and held for the whole transform. When set, tw_index = (16 - k<<(3-s)) & 15, the conjugate twiddle; e.g. forward index 2 becomes 14, and 0 stays 0.
- Undefined: no inverse port; forward indices only.

Test Plan:
- Reset then start with LOG2N=4, DRAIN=3, bf_ready tied 1 -> stage 0 issues (0,1,tw0),(2,3,tw0)...(14,15,tw0). Stage 3, j=5 gives (5,13,tw5). 32 handshakes total; done exactly 46 cycles after start; last_bf only on stage3 j=7 (7,15,tw7).
- Stage 1, j=3, bf_ready=1 -> addr_a=5, addr_b=7, tw_index=4. Stage 2, j=6 -> addr_a=10, addr_b=14, tw_index=4.
- bf_ready toggling 1,0,0,1 pseudo-randomly -> outputs frozen during every stall cycle; handshake sequence identical to the unstalled run; bf_valid low for exactly 3 cycles between stages.
- start pulses while busy, plus a start in the DONE cycle -> ignored; exactly one done pulse. A start two cycles after done -> second transform runs normally.
- rst_n pulled low at stage 2, j=4 -> all outputs 0 asynchronously, no done. After release, start -> full 46-cycle run from stage 0.
- FFT_INVERSE_EN defined with inverse=1 -> stage 3, j=1 gives tw_index=15; j=0 gives 0. With inverse=0 the sequence is identical to the forward run.

Source files
------------

// File: rtl/fft_addr_sched.sv
// fft_addr_sched: address and twiddle sequencer for an in-place radix-2
// decimation-in-time FFT of N = 2^LOG2N points held in a single-port RAM.
// Issues one butterfly per accepted handshake and runs stage by stage.
// After each stage it waits DRAIN idle cycles so that butterfly write-backs
// land before the next stage reads.
// Optional build macro FFT_INVERSE_EN adds an 'inverse' input. That input is
// sampled at an accepted start and selects conjugate twiddle indices.
//
// Handshake: a butterfly transfers on a rising edge where bf_valid && bf_ready.
// While bf_valid is high and bf_ready is low, every output holds its value.
// bf_valid never drops without a transfer.
module fft_addr_sched #(
    parameter int LOG2N = 4,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef FFT_INVERSE_EN
    input  logic             inverse,
`endif
    output logic             busy,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [3:0]       tw_index,
    output logic [1:0]       stage,
    output logic             last_bf,
    output logic             done
);

    localparam int JW = LOG2N - 1;
    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [1:0]    S_LAST = 2'(LOG2N - 1);
    localparam logic [3:0]    D_LAST = 4'(DRAIN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q;
    logic [JW-1:0] j_q;
    logic [1:0]    stage_q;
    logic [3:0]    drain_q;
    logic          final_q;
    // Set once reset has been seen released on an edge. A start that
    // coincides with reset release is therefore ignored.
    logic          rst_seen_q;
`ifdef FFT_INVERSE_EN
    logic          inv_q;
`endif

    // Sequencer: stage/butterfly counters, inter-stage drain and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            stage_q    <= '0;
            drain_q    <= '0;
            final_q    <= 1'b0;
            rst_seen_q <= 1'b0;
`ifdef FFT_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            rst_seen_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start && rst_seen_q) begin
                        state_q <= S_ISSUE;
                        stage_q <= '0;
                        j_q     <= '0;
                        drain_q <= '0;
                        final_q <= 1'b0;
`ifdef FFT_INVERSE_EN
                        inv_q   <= inverse;
`endif
                    end
                end
                S_ISSUE: begin
                    if (bf_ready) begin
                        if (j_q == J_LAST) begin
                            if (DRAIN == 0) begin
                                // No drain gap: next stage issues right away.
                                if (stage_q == S_LAST) begin
                                    state_q <= S_DONE;
                                end else begin
                                    stage_q <= stage_q + 2'd1;
                                    j_q     <= '0;
                                end
                            end else begin
                                state_q <= S_DRAIN;
                                drain_q <= '0;
                                final_q <= (stage_q == S_LAST);
                            end
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == D_LAST) begin
                        if (final_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                            stage_q <= stage_q + 2'd1;
                            j_q     <= '0;
                        end
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bf_valid = (state_q == S_ISSUE);
    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign stage    = stage_q;
    assign last_bf  = bf_valid && (stage_q == S_LAST) && (j_q == J_LAST);

    logic [3:0] j_ext;
    logic [3:0] span;
    logic [3:0] k_val;
    logic [3:0] grp;
    logic [3:0] a_full;
    logic [3:0] b_full;
    logic [3:0] tw_fwd;
    logic [3:0] tw_sel;

    // Butterfly addresses and twiddle index. These are forced to zero when
    // nothing is issued, so an async reset clears them at once.
    always_comb begin
        j_ext  = 4'(j_q);
        span   = 4'd1 << stage_q;
        k_val  = j_ext & (span - 4'd1);
        grp    = j_ext >> stage_q;
        a_full = (grp << ({1'b0, stage_q} + 3'd1)) + k_val;
        b_full = a_full + span;
        tw_fwd = k_val << (3'd3 - {1'b0, stage_q});
`ifdef FFT_INVERSE_EN
        tw_sel = inv_q ? (4'd0 - tw_fwd) : tw_fwd;
`else
        tw_sel = tw_fwd;
`endif
        addr_a   = '0;
        addr_b   = '0;
        tw_index = '0;
        if (bf_valid) begin
            addr_a   = a_full[LOG2N-1:0];
            addr_b   = b_full[LOG2N-1:0];
            tw_index = tw_sel;
        end
    end

endmodule

// File: tb/tb_fft_addr_sched.sv
// Self-checking bench for fft_addr_sched (LOG2N=4, DRAIN=3).
// The expected butterfly list comes from the textbook DIT block/offset
// enumeration, not from the j/stage bit arithmetic.
module tb_fft_addr_sched;

    localparam int LOG2N = 4;
    localparam int DRAIN = 3;
    localparam int N     = 1 << LOG2N;
    localparam int NHS   = (N / 2) * LOG2N;
    localparam int LAT   = 1 + LOG2N * (N / 2 + DRAIN) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       bf_ready = 1'b0;
`ifdef FFT_INVERSE_EN
    logic       inverse = 1'b0;
`endif
    logic       busy, bf_valid, last_bf, done;
    logic [3:0] addr_a, addr_b, tw_index;
    logic [1:0] stage;

    int errors = 0;
    int checks = 0;

    // Entry layout: {last_bf, stage[1:0], addr_a[3:0], addr_b[3:0], tw_index[3:0]}
    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    int          gap_q[$];
    int          lat, done_cnt, done_busy, post_busy, freeze_err, last_err, stall_cycles;
    bit          finished;
    logic [14:0] pre_abort;
    logic [17:0] abort_snap;

    fft_addr_sched #(.LOG2N(LOG2N), .DRAIN(DRAIN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef FFT_INVERSE_EN
        .inverse  (inverse),
`endif
        .busy     (busy),
        .bf_valid (bf_valid),
        .bf_ready (bf_ready),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .tw_index (tw_index),
        .stage    (stage),
        .last_bf  (last_bf),
        .done     (done)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: for each stage, blocks of 2*span points, with the upper
    // leg at base+k and the lower leg at base+k+span. The twiddle index for
    // W_(2*span)^k in the 16-entry ROM is k*(8/span).
    function automatic void build_expected(input bit inv);
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            int span;
            span = 1 << s;
            for (int base = 0; base < N; base += 2 * span) begin
                for (int k = 0; k < span; k++) begin
                    int tw;
                    bit last;
                    tw = k * (8 / span);
                    if (inv) tw = (16 - tw) % 16;
                    last = (s == LOG2N - 1) && (base + 2 * span == N) && (k == span - 1);
                    exp_q.push_back({last, 2'(s), 4'(base + k), 4'(base + k + span), 4'(tw)});
                end
            end
        end
    endfunction

    // Driver/monitor: pulses start and drives bf_ready each cycle, then logs
    // every handshake and the cycle-level observations. Cycle 1 is the cycle
    // in which start is high. When abort_at >= 0, rst_n is pulled low while
    // handshake number abort_at is being presented.
    task automatic run_transform(input int stall_pct, input bit inv, input bit noisy, input int abort_at);
        bit          prev_stall;
        logic [14:0] prev_out, cur;
        int          gap;
        obs_q.delete();
        gap_q.delete();
        lat = 0; done_cnt = 0; done_busy = 0; post_busy = 0;
        freeze_err = 0; last_err = 0; stall_cycles = 0; finished = 0;
        prev_stall = 0; prev_out = '0; gap = 0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 1) start = 1'b1;
            else if (noisy && (busy || done)) start = done || ($urandom_range(0, 2) == 0);
            else start = 1'b0;
`ifdef FFT_INVERSE_EN
            if (cyc == 1) inverse = inv;
            else if (noisy) inverse = 1'($urandom_range(0, 1));
`endif
            bf_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            cur = {last_bf, stage, addr_a, addr_b, tw_index};
            if (prev_stall && (!bf_valid || cur !== prev_out)) freeze_err++;
            if (!bf_valid && last_bf) last_err++;
            if (abort_at >= 0 && bf_valid && obs_q.size() == abort_at) begin
                pre_abort = cur;
                rst_n = 1'b0;
                #1;
                abort_snap = {busy, bf_valid, last_bf, done, stage, addr_a, addr_b, tw_index};
                start = 1'b0;
                bf_ready = 1'b0;
                return;
            end
            if (bf_valid && bf_ready) obs_q.push_back(cur);
            if (bf_valid && !bf_ready) stall_cycles++;
            if (busy && !bf_valid) begin
                gap++;
            end else begin
                if (bf_valid && gap > 0) gap_q.push_back(gap);
                gap = 0;
            end
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = cyc;
                if (busy) done_busy++;
            end else if (lat != 0 && busy) begin
                post_busy++;
            end
            prev_stall = bf_valid && !bf_ready;
            prev_out = cur;
            if (lat != 0 && cyc == lat + 1) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, bf_valid, last_bf, done, stage, addr_a, addr_b, tw_index} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, bf_valid, last_bf, done, stage, addr_a, addr_b, tw_index});
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_start_same_cycle;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || bf_valid !== 1'b0) begin
                errors++;
                $display("FAIL start_at_reset_release[%0d]: busy=%b bf_valid=%b expected 0 0", i, busy, bf_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_forward;
        int          idx_l[6];
        logic [14:0] val_l[6];
        idx_l = '{0, 7, 11, 22, 29, 31};
        val_l = '{{1'b0, 2'd0, 4'd0, 4'd1, 4'd0},  {1'b0, 2'd0, 4'd14, 4'd15, 4'd0},
                  {1'b0, 2'd1, 4'd5, 4'd7, 4'd4},  {1'b0, 2'd2, 4'd10, 4'd14, 4'd4},
                  {1'b0, 2'd3, 4'd5, 4'd13, 4'd5}, {1'b1, 2'd3, 4'd7, 4'd15, 4'd7}};
        build_expected(1'b0);
        run_transform(0, 1'b0, 1'b0, -1);
        checks++;
        if (!finished) begin errors++; $display("FAIL fwd_timeout: no done within budget"); end
        checks++;
        if (obs_q.size() != NHS) begin errors++; $display("FAIL fwd_count: got %0d expected %0d", obs_q.size(), NHS); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL fwd_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_q[idx_l[i]] !== val_l[i]) begin errors++; $display("FAIL fwd_spot[%0d]: got %h expected %h", idx_l[i], obs_q[idx_l[i]], val_l[i]); end
        end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL fwd_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (done_cnt != 1 || done_busy != 0) begin errors++; $display("FAIL fwd_done: pulses=%0d busy_in_done=%0d expected 1 0", done_cnt, done_busy); end
        checks++;
        if (last_err != 0) begin errors++; $display("FAIL fwd_last_unqualified: got %0d expected 0", last_err); end
        checks++;
        if (gap_q.size() != ((DRAIN > 0) ? LOG2N - 1 : 0)) begin errors++; $display("FAIL fwd_gap_count: got %0d expected %0d", gap_q.size(), LOG2N - 1); end
        foreach (gap_q[i]) begin
            checks++;
            if (gap_q[i] != DRAIN) begin errors++; $display("FAIL fwd_gap[%0d]: got %0d expected %0d", i, gap_q[i], DRAIN); end
        end
    endtask

    task automatic test_stall;
        build_expected(1'b0);
        run_transform(40, 1'b0, 1'b0, -1);
        checks++;
        if (!finished) begin errors++; $display("FAIL stall_timeout: no done within budget"); end
        checks++;
        if (obs_q.size() != NHS) begin errors++; $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), NHS); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (stall_cycles == 0 || freeze_err != 0) begin errors++; $display("FAIL stall_freeze: violations=%0d stalls=%0d expected 0 and >0", freeze_err, stall_cycles); end
        checks++;
        if (gap_q.size() != LOG2N - 1) begin errors++; $display("FAIL stall_gap_count: got %0d expected %0d", gap_q.size(), LOG2N - 1); end
        foreach (gap_q[i]) begin
            checks++;
            if (gap_q[i] != DRAIN) begin errors++; $display("FAIL stall_gap[%0d]: got %0d expected %0d", i, gap_q[i], DRAIN); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored;
        build_expected(1'b0);
        run_transform(0, 1'b0, 1'b1, -1);
        checks++;
        if (!finished || lat != LAT) begin errors++; $display("FAIL noisy_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (obs_q.size() != NHS) begin errors++; $display("FAIL noisy_count: got %0d expected %0d", obs_q.size(), NHS); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL noisy_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (done_cnt != 1 || post_busy != 0) begin errors++; $display("FAIL noisy_done: pulses=%0d busy_after=%0d expected 1 0", done_cnt, post_busy); end
    endtask

    task automatic test_back_to_back;
        build_expected(1'b0);
        run_transform(0, 1'b0, 1'b0, -1);
        checks++;
        if (!finished || lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort;
        run_transform(0, 1'b0, 1'b0, 2 * (N / 2) + 4);
        checks++;
        if (pre_abort !== {1'b0, 2'd2, 4'd8, 4'd12, 4'd0}) begin errors++; $display("FAIL abort_point: got %h expected %h", pre_abort, {1'b0, 2'd2, 4'd8, 4'd12, 4'd0}); end
        checks++;
        if (abort_snap !== 18'd0) begin errors++; $display("FAIL abort_async_clear: got %h expected 0", abort_snap); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_hold[%0d]: done=%b busy=%b expected 0 0", i, done, busy); end
        end
        rst_n = 1'b1;
        build_expected(1'b0);
        run_transform(0, 1'b0, 1'b0, -1);
        checks++;
        if (!finished || lat != LAT) begin errors++; $display("FAIL abort_rerun_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (obs_q.size() != NHS || obs_q[0] !== exp_q[0] || obs_q[NHS-1] !== exp_q[NHS-1]) begin
            errors++;
            $display("FAIL abort_rerun_seq: count=%0d first=%h last=%h expected %0d %h %h",
                     obs_q.size(), obs_q[0], obs_q[NHS-1], NHS, exp_q[0], exp_q[NHS-1]);
        end
    endtask

`ifdef FFT_INVERSE_EN
    task automatic test_inverse;
        build_expected(1'b1);
        run_transform(20, 1'b1, 1'b0, -1);
        checks++;
        if (obs_q.size() != NHS) begin errors++; $display("FAIL inv_count: got %0d expected %0d", obs_q.size(), NHS); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL inv_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (obs_q[25][3:0] !== 4'd15 || obs_q[24][3:0] !== 4'd0) begin
            errors++;
            $display("FAIL inv_spot: tw j1=%0d j0=%0d expected 15 0", obs_q[25][3:0], obs_q[24][3:0]);
        end
        build_expected(1'b0);
        run_transform(0, 1'b0, 1'b0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL inv_off_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_start_same_cycle;
        test_forward;
        test_stall;
        test_start_ignored;
        test_back_to_back;
        test_abort;
`ifdef FFT_INVERSE_EN
        test_inverse;
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
